// File: rtl/regfile_mp_pc_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// the location of the PC inside the register array and its reset value.
package regfile_mp_pc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  localparam logic [DATA_W_DEF-1:0] PC_RESET = 16'h0000;

  // The PC always occupies the highest register index
  function automatic int pc_idx(input int addr_w);
    return (32'sd1 <<< addr_w) - 32'sd1;
  endfunction

endpackage

// File: rtl/regfile_mp_pc_if.sv
// Decode/writeback-facing bus of the register file: write ports, read ports,
// scoreboard set and PC update path.
interface regfile_mp_pc_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int N_RD     = 2,
  parameter int N_PC_SRC = 10
);
  localparam int NREGS = 2 ** ADDR_W;

  logic                       wr0_en;
  logic [ADDR_W-1:0]          wr0_addr;
  logic [DATA_W-1:0]          wr0_data;
  logic                       wr1_en;
  logic [ADDR_W-1:0]          wr1_addr;
  logic [DATA_W-1:0]          wr1_data;
  logic [N_RD*ADDR_W-1:0]     rd_addr;
  logic [N_RD*DATA_W-1:0]     rd_data;
  logic [N_RD-1:0]            rd_busy;
  logic                       sb_set;
  logic [ADDR_W-1:0]          sb_addr;
  logic                       pc_en;
  logic [N_PC_SRC-2:0]        pc_cond;
  logic [N_PC_SRC*DATA_W-1:0] pc_src;
  logic [DATA_W-1:0]          pc_out;
  logic [NREGS-1:0]           busy_vec;

  modport master (
    output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    output rd_addr, sb_set, sb_addr, pc_en, pc_cond, pc_src,
    input  rd_data, rd_busy, pc_out, busy_vec
  );

  modport slave (
    input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
    input  rd_addr, sb_set, sb_addr, pc_en, pc_cond, pc_src,
    output rd_data, rd_busy, pc_out, busy_vec
  );

endinterface

// File: rtl/regfile_mp_pc_pc_next_mux.sv
// Priority mux selecting the next PC: lowest asserted condition wins, the
// last source is the unconditional fallback.
module pc_next_mux #(
  parameter int N_PC_SRC = 10,
  parameter int DATA_W   = 16
) (
  input  logic [N_PC_SRC-2:0]        cond,
  input  logic [N_PC_SRC*DATA_W-1:0] src,
  output logic [DATA_W-1:0]          next_pc
);

  // Scan from highest to lowest so the lowest set condition is applied last
  always_comb begin
    next_pc = src[(N_PC_SRC-1)*DATA_W +: DATA_W];
    for (int j = N_PC_SRC - 2; j >= 0; j--) begin
      next_pc = cond[j] ? src[j*DATA_W +: DATA_W] : next_pc;
    end
  end

endmodule

// File: rtl/regfile_mp_pc.sv
// Multi-port register file with the architectural PC in the top register,
// dual writeback ports, optional write-to-read bypass and a pending-write scoreboard.
module regfile_mp_pc
  import regfile_mp_pc_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_RD     = 2,
  parameter int N_PC_SRC = 10,
  parameter int BYPASS   = 1
) (
  input logic           clk,
  input logic           rst,
  regfile_mp_pc_if.slave bus
);

  localparam int                NREGS   = 2 ** ADDR_W;
  localparam int                PC_I    = pc_idx(ADDR_W);
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_I);

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  busy_r;
  logic [DATA_W-1:0] next_pc_s;
  logic              wr0_ok_s;
  logic              wr1_ok_s;
  logic [ADDR_W-1:0] rd_a_s   [N_RD];
  logic              hit0_s   [N_RD];
  logic              hit1_s   [N_RD];

  // The PC can only change through the pc_* path, never through a write port
  assign wr0_ok_s = bus.wr0_en && (bus.wr0_addr != PC_ADDR);
  assign wr1_ok_s = bus.wr1_en && (bus.wr1_addr != PC_ADDR);

  pc_next_mux #(
    .N_PC_SRC (N_PC_SRC),
    .DATA_W   (DATA_W)
  ) u_pc_next_mux (
    .cond    (bus.pc_cond),
    .src     (bus.pc_src),
    .next_pc (next_pc_s)
  );

  // Register array and PC update; wr1 (younger load) overrides wr0 on conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        if (r == PC_I) begin
          regs_r[r] <= DATA_W'(PC_RESET);
        end else begin
          regs_r[r] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (r == PC_I) begin
          if (bus.pc_en) begin
            regs_r[r] <= next_pc_s;
          end
        end else if (wr1_ok_s && (bus.wr1_addr == ADDR_W'(r))) begin
          regs_r[r] <= bus.wr1_data;
        end else if (wr0_ok_s && (bus.wr0_addr == ADDR_W'(r))) begin
          regs_r[r] <= bus.wr0_data;
        end
      end
    end
  end

  // Scoreboard: a new producer (set) outranks a retiring one (clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (r == PC_I) begin
          busy_r[r] <= 1'b0;
        end else if (bus.sb_set && (bus.sb_addr == ADDR_W'(r))) begin
          busy_r[r] <= 1'b1;
        end else if ((bus.wr0_en && (bus.wr0_addr == ADDR_W'(r))) ||
                     (bus.wr1_en && (bus.wr1_addr == ADDR_W'(r)))) begin
          busy_r[r] <= 1'b0;
        end
      end
    end
  end

  // Combinational read ports with optional forwarding of same-cycle writes
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    rd_a_s      = '{default: '0};
    hit0_s      = '{default: 1'b0};
    hit1_s      = '{default: 1'b0};
    for (int k = 0; k < N_RD; k++) begin
      rd_a_s[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
      hit1_s[k] = (BYPASS != 0) && wr1_ok_s && (bus.wr1_addr == rd_a_s[k]);
      hit0_s[k] = (BYPASS != 0) && wr0_ok_s && (bus.wr0_addr == rd_a_s[k]);
      if (rd_a_s[k] == PC_ADDR) begin
        bus.rd_data[k*DATA_W +: DATA_W] = regs_r[PC_I];
      end else if (hit1_s[k]) begin
        bus.rd_data[k*DATA_W +: DATA_W] = bus.wr1_data;
      end else if (hit0_s[k]) begin
        bus.rd_data[k*DATA_W +: DATA_W] = bus.wr0_data;
      end else begin
        bus.rd_data[k*DATA_W +: DATA_W] = regs_r[rd_a_s[k]];
      end
      bus.rd_busy[k] = (hit0_s[k] || hit1_s[k]) ? 1'b0 : busy_r[rd_a_s[k]];
    end
  end

  assign bus.pc_out   = regs_r[PC_I];
  assign bus.busy_vec = busy_r;

endmodule

// File: tb/tb_regfile_mp_pc.sv
// Self-checking bench: directed scenarios plus random traffic on a bypassing
// and a non-bypassing instance, both compared against one array-based model.
module tb_regfile_mp_pc;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 2;
  localparam int NP = 10;
  localparam int NREGS = 8;
  localparam int PCI = 7;
  localparam logic [AW-1:0] PC_ADDR = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              wr0_en, wr1_en, sb_set, pc_en;
  logic [AW-1:0]     wr0_addr, wr1_addr, sb_addr;
  logic [DW-1:0]     wr0_data, wr1_data;
  logic [NR*AW-1:0]  rd_addr;
  logic [NP-2:0]     pc_cond;
  logic [NP*DW-1:0]  pc_src;

  regfile_mp_pc_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_PC_SRC(NP)) bus_b1 ();
  regfile_mp_pc_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_PC_SRC(NP)) bus_b0 ();

  assign bus_b1.wr0_en = wr0_en;   assign bus_b0.wr0_en = wr0_en;
  assign bus_b1.wr0_addr = wr0_addr; assign bus_b0.wr0_addr = wr0_addr;
  assign bus_b1.wr0_data = wr0_data; assign bus_b0.wr0_data = wr0_data;
  assign bus_b1.wr1_en = wr1_en;   assign bus_b0.wr1_en = wr1_en;
  assign bus_b1.wr1_addr = wr1_addr; assign bus_b0.wr1_addr = wr1_addr;
  assign bus_b1.wr1_data = wr1_data; assign bus_b0.wr1_data = wr1_data;
  assign bus_b1.rd_addr = rd_addr; assign bus_b0.rd_addr = rd_addr;
  assign bus_b1.sb_set = sb_set;   assign bus_b0.sb_set = sb_set;
  assign bus_b1.sb_addr = sb_addr; assign bus_b0.sb_addr = sb_addr;
  assign bus_b1.pc_en = pc_en;     assign bus_b0.pc_en = pc_en;
  assign bus_b1.pc_cond = pc_cond; assign bus_b0.pc_cond = pc_cond;
  assign bus_b1.pc_src = pc_src;   assign bus_b0.pc_src = pc_src;

  regfile_mp_pc #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_PC_SRC(NP), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst), .bus(bus_b1.slave)
  );
  regfile_mp_pc #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_PC_SRC(NP), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst), .bus(bus_b0.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]    m_reg [NREGS];
  logic [NREGS-1:0] m_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read value as seen by an instruction in decode this cycle
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == PC_ADDR) return m_reg[PCI];
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (byp && a != PC_ADDR && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a)))
      return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_outputs();
    logic [AW-1:0] a;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      check($sformatf("b1_rd_data%0d", k), 32'(bus_b1.rd_data[k*DW +: DW]), 32'(exp_rd(a, 1'b1)));
      check($sformatf("b0_rd_data%0d", k), 32'(bus_b0.rd_data[k*DW +: DW]), 32'(exp_rd(a, 1'b0)));
      check($sformatf("b1_rd_busy%0d", k), 32'(bus_b1.rd_busy[k]), 32'(exp_busy(a, 1'b1)));
      check($sformatf("b0_rd_busy%0d", k), 32'(bus_b0.rd_busy[k]), 32'(exp_busy(a, 1'b0)));
    end
    check("b1_pc_out", 32'(bus_b1.pc_out), 32'(m_reg[PCI]));
    check("b0_pc_out", 32'(bus_b0.pc_out), 32'(m_reg[PCI]));
    check("b1_busy_vec", 32'(bus_b1.busy_vec), 32'(m_busy));
    check("b0_busy_vec", 32'(bus_b0.busy_vec), 32'(m_busy));
  endtask

  // Architectural effect of one clock edge
  task automatic model_update();
    logic [DW-1:0] nxt [NREGS];
    int sel;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) m_reg[r] = '0;
      m_busy = '0;
    end else begin
      nxt = m_reg;
      if (wr0_en && wr0_addr != PC_ADDR) nxt[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != PC_ADDR) nxt[wr1_addr] = wr1_data;
      if (pc_en) begin
        sel = NP - 1;
        for (int j = NP - 2; j >= 0; j--) if (pc_cond[j]) sel = j;
        nxt[PCI] = pc_src[sel*DW +: DW];
      end
      if (wr0_en) m_busy[wr0_addr] = 1'b0;
      if (wr1_en) m_busy[wr1_addr] = 1'b0;
      if (sb_set && sb_addr != PC_ADDR) m_busy[sb_addr] = 1'b1;
      m_reg = nxt;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr0_en = 1'b0; wr1_en = 1'b0; sb_set = 1'b0; pc_en = 1'b0;
    wr0_addr = '0; wr1_addr = '0; sb_addr = '0; wr0_data = '0; wr1_data = '0;
    rd_addr = '0; pc_cond = '0; pc_src = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    for (int r = 0; r < NREGS; r++) m_reg[r] = 16'hDEAD;
    m_busy = '0;
    @(posedge clk); model_update(); #1;
    rst = 1'b0;

    // Reset mid-operation after preloading R1 and the PC
    wr0_en = 1'b1; wr0_addr = 3'd1; wr0_data = 16'h1234;
    pc_en = 1'b1; pc_src[9*DW +: DW] = 16'h0040; sb_set = 1'b1; sb_addr = 3'd5;
    cycle();
    check("preload_pc", 32'(bus_b1.pc_out), 32'h0040);
    rst = 1'b1; wr0_addr = 3'd2;
    cycle();
    idle(); rd_addr = {3'd7, 3'd1}; #1;
    check("rst_r1", 32'(bus_b1.rd_data[DW-1:0]), 32'h0);
    check("rst_pc", 32'(bus_b1.pc_out), 32'h0);
    check("rst_busy", 32'(bus_b1.busy_vec), 32'h0);
    cycle();

    // Same-address write conflict, then an ignored write to the PC register
    wr0_en = 1'b1; wr0_addr = 3'd3; wr0_data = 16'hAAAA;
    wr1_en = 1'b1; wr1_addr = 3'd3; wr1_data = 16'h5555;
    cycle();
    idle(); rd_addr = {3'd0, 3'd3}; #1;
    check("conflict_r3", 32'(bus_b0.rd_data[DW-1:0]), 32'h5555);
    wr0_en = 1'b1; wr0_addr = 3'd7; wr0_data = 16'hFFFF;
    cycle();
    idle(); #1;
    check("pc_write_ignored", 32'(bus_b1.pc_out), 32'h0);

    // Bypass versus no-bypass on the same stimulus
    wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 16'h0011;
    cycle();
    idle(); wr0_en = 1'b1; wr0_addr = 3'd2; wr0_data = 16'h00C3; rd_addr = {3'd0, 3'd2}; #1;
    check("bypass_on", 32'(bus_b1.rd_data[DW-1:0]), 32'h00C3);
    check("bypass_off", 32'(bus_b0.rd_data[DW-1:0]), 32'h0011);
    cycle();

    // PC priority selection
    idle();
    for (int j = 0; j < NP; j++) pc_src[j*DW +: DW] = 16'(16'h0100 + j);
    pc_en = 1'b1; pc_cond = 9'b000010100;
    cycle();
    check("pc_lowest_cond", 32'(bus_b1.pc_out), 32'h0102);
    pc_cond = 9'b000000000;
    cycle();
    check("pc_default", 32'(bus_b1.pc_out), 32'h0109);
    pc_en = 1'b0; pc_cond = 9'b111111111; pc_src = '1;
    cycle();
    check("pc_hold", 32'(bus_b1.pc_out), 32'h0109);

    // Scoreboard set, clear, set-wins and PC-address set
    idle(); sb_set = 1'b1; sb_addr = 3'd4;
    cycle();
    idle(); rd_addr = {3'd4, 3'd4}; #1;
    check("sb_set_vec", 32'(bus_b1.busy_vec[4]), 32'h1);
    check("sb_rd_busy", 32'(bus_b1.rd_busy[0]), 32'h1);
    wr1_en = 1'b1; wr1_addr = 3'd4; wr1_data = 16'h4444;
    cycle();
    idle(); #1;
    check("sb_clear", 32'(bus_b1.busy_vec[4]), 32'h0);
    sb_set = 1'b1; sb_addr = 3'd4;
    cycle();
    wr0_en = 1'b1; wr0_addr = 3'd4; wr0_data = 16'h4545;
    cycle();
    idle(); #1;
    check("sb_set_wins", 32'(bus_b1.busy_vec[4]), 32'h1);
    sb_set = 1'b1; sb_addr = 3'd7;
    cycle();
    idle(); #1;
    check("sb_pc_ignored", 32'(bus_b1.busy_vec[7]), 32'h0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      rst      = ($urandom_range(0, 499) == 0);
      wr0_en   = 1'($urandom_range(0, 1));
      wr0_addr = 3'($urandom_range(0, 7));
      wr0_data = 16'($urandom);
      wr1_en   = 1'($urandom_range(0, 1));
      wr1_addr = 3'($urandom_range(0, 7));
      wr1_data = 16'($urandom);
      rd_addr  = 6'($urandom);
      sb_set   = 1'($urandom_range(0, 1));
      sb_addr  = 3'($urandom_range(0, 7));
      pc_en    = 1'($urandom_range(0, 1));
      pc_cond  = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom & $urandom);
      for (int j = 0; j < NP; j++) pc_src[j*DW +: DW] = 16'($urandom);
      cycle();
    end

    idle();
    cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
